// File: rtl/f_pc.sv
// ----------------------------------------------------------------------------
// f_pc -- fetch-stage program counter with redirect, exception and eret
// handling plus a small RUN/HOLD/VEC status FSM.
//
// Next-PC priority (highest first): req -> 0x0000_4180, eret -> EPC,
// F_stall -> hold, D_npc_sel 1/2 -> D_target, otherwise F_PC + 4 (wraps).
// Reset is synchronous, active-high and beats every other input.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous active-high reset
//   F_stall      in   1   hazard-unit freeze of fetch
//   D_npc_sel    in   2   0 seq, 1 branch taken, 2 jump, 3 treated as seq
//   D_target     in  32   redirect target from D
//   req          in   1   CP0 exception/interrupt request
//   eret         in   1   eret resolved in D
//   EPC          in  32   CP0 return address
//   F_PC         out 32   current fetch address
//   F_ExcCode    out  5   0 none, 4 AdEL (misaligned or outside IM window)
//   F_state      out  2   0 RUN, 1 HOLD, 2 VEC
//   F_fetch_cnt  out 32   saturating advanced-fetch counter
//
// Optional feature macro: F_FETCH_CNT_EN adds the F_fetch_cnt port, its
// register and logic. Without it the block behaves identically otherwise.
// ----------------------------------------------------------------------------
module f_pc (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_stall,
    input  logic [1:0]  D_npc_sel,
    input  logic [31:0] D_target,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] EPC,
    output logic [31:0] F_PC,
    output logic [4:0]  F_ExcCode,
`ifdef F_FETCH_CNT_EN
    output logic [1:0]  F_state,
    output logic [31:0] F_fetch_cnt
`else
    output logic [1:0]  F_state
`endif
);

    localparam logic [31:0] ResetPc   = 32'h0000_3000;
    localparam logic [31:0] ExcVector = 32'h0000_4180;
    localparam logic [31:0] ImLo      = 32'h0000_3000;
    localparam logic [31:0] ImHi      = 32'h0000_6FFF;
    localparam logic [4:0]  ExcNone   = 5'd0;
    localparam logic [4:0]  ExcAdEL   = 5'd4;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StHold = 2'd1,
        StVec  = 2'd2
    } state_e;

    logic [31:0] pc_q, pc_d;
    state_e      state_q, state_d;

    // Next PC: later assignments override earlier ones, giving the priority
    // req > eret > F_stall > D_npc_sel.
    always_comb begin
        pc_d = pc_q + 32'd4;
        unique case (D_npc_sel)
            2'd1, 2'd2: pc_d = D_target;
            default:    pc_d = pc_q + 32'd4;
        endcase
        if (F_stall) begin
            pc_d = pc_q;
        end
        if (eret) begin
            pc_d = EPC;
        end
        if (req) begin
            pc_d = ExcVector;
        end
    end

    // The same rule set applies from every state; an eret during HOLD moves
    // the PC, so the FSM must leave HOLD to keep HOLD meaning "PC frozen".
    always_comb begin
        state_d = StRun;
        if (req) begin
            state_d = StVec;
        end else if (eret) begin
            state_d = StRun;
        end else if (F_stall) begin
            state_d = StHold;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= ResetPc;
            state_q <= StRun;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

`ifdef F_FETCH_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Counts cycles in which the PC is allowed to move; sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if ((!F_stall || req || eret) && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign F_fetch_cnt = cnt_q;
`endif

    assign F_PC      = pc_q;
    assign F_state   = state_q;
    assign F_ExcCode = ((pc_q[1:0] != 2'b00) || (pc_q < ImLo) || (pc_q > ImHi))
                       ? ExcAdEL : ExcNone;

endmodule

// File: tb/tb_f_pc.sv
module tb_f_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_stall;
    logic [1:0]  D_npc_sel;
    logic [31:0] D_target;
    logic        req;
    logic        eret;
    logic [31:0] EPC;
    logic [31:0] F_PC;
    logic [4:0]  F_ExcCode;
    logic [1:0]  F_state;
`ifdef F_FETCH_CNT_EN
    logic [31:0] F_fetch_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    f_pc dut (
        .clk        (clk),
        .reset      (reset),
        .F_stall    (F_stall),
        .D_npc_sel  (D_npc_sel),
        .D_target   (D_target),
        .req        (req),
        .eret       (eret),
        .EPC        (EPC),
        .F_PC       (F_PC),
        .F_ExcCode  (F_ExcCode),
`ifdef F_FETCH_CNT_EN
        .F_state    (F_state),
        .F_fetch_cnt(F_fetch_cnt)
`else
        .F_state    (F_state)
`endif
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        rq;
        logic        er;
        logic [31:0] epc;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic [4:0]  e_exc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [31:0] m_pc;
    int          m_st;
    logic [31:0] m_cnt;

    task automatic add(input string name, input logic rst, input logic stall,
                       input logic [1:0] sel, input logic [31:0] tgt, input logic rq,
                       input logic er, input logic [31:0] epc, input logic [31:0] e_pc,
                       input logic [1:0] e_st, input logic [4:0] e_exc);
        vec_t v;
        v.name = name; v.rst = rst; v.stall = stall; v.sel = sel; v.tgt = tgt;
        v.rq = rq; v.er = er; v.epc = epc; v.e_pc = e_pc; v.e_st = e_st; v.e_exc = e_exc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic [1:0] sel,
                         input logic [31:0] tgt, input logic rq, input logic er,
                         input logic [31:0] epc);
        reset = rst; F_stall = stall; D_npc_sel = sel; D_target = tgt;
        req = rq; eret = er; EPC = epc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] exp_exc(input logic [31:0] pc);
        if (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFF) return 5'd4;
        return 5'd0;
    endfunction

    // Specification-level next-state rules applied to the model.
    task automatic model_step(input logic rst, input logic stall, input logic [1:0] sel,
                              input logic [31:0] tgt, input logic rq, input logic er,
                              input logic [31:0] epc);
        if (rst) begin
            m_pc = 32'h3000; m_st = 0; m_cnt = 0;
        end else begin
            if ((!stall || rq || er) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (rq) begin
                m_pc = 32'h4180; m_st = 2;
            end else if (er) begin
                m_pc = epc; m_st = 0;
            end else if (stall) begin
                m_st = 1;
            end else begin
                m_pc = (sel == 2'd1 || sel == 2'd2) ? tgt : m_pc + 32'd4;
                m_st = 0;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'h3000 + 32'd4 * $urandom_range(0, 4095);
    endfunction

    initial begin
        reset = 1'b1; F_stall = 1'b0; D_npc_sel = 2'd0; D_target = '0;
        req = 1'b0; eret = 1'b0; EPC = '0;

        //   name          rst st sel tgt            rq er epc            e_pc           st  exc
        add("reset",       1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h3000,      0, 0);
        add("free1",       0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h3004,      0, 0);
        add("free2",       0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h3008,      0, 0);
        add("free3",       0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h300C,      0, 0);
        add("reset2",      1, 0, 0, 32'h0,         0, 0, 32'h0,         32'h3000,      0, 0);
        add("seq_a",       0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h3004,      0, 0);
        add("seq_b",       0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h3008,      0, 0);
        add("stall1",      0, 1, 1, 32'h3100,      0, 0, 32'h0,         32'h3008,      1, 0);
        add("stall2",      0, 1, 1, 32'h3100,      0, 0, 32'h0,         32'h3008,      1, 0);
        add("branch",      0, 0, 1, 32'h3100,      0, 0, 32'h0,         32'h3100,      0, 0);
        add("jump",        0, 0, 2, 32'h3010,      0, 0, 32'h0,         32'h3010,      0, 0);
        add("req_stall",   0, 1, 0, 32'h0,         1, 0, 32'h0,         32'h4180,      2, 0);
        add("after_vec",   0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h4184,      0, 0);
        add("eret",        0, 0, 0, 32'h0,         0, 1, 32'h3022,      32'h3022,      0, 4);
        add("req_eret",    0, 0, 0, 32'h0,         1, 1, 32'h3022,      32'h4180,      2, 0);
        add("req_again",   0, 0, 1, 32'h5000,      1, 0, 32'h0,         32'h4180,      2, 0);
        add("vec_stall",   0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h4180,      1, 0);
        add("sel3_seq",    0, 0, 3, 32'h5000,      0, 0, 32'h0,         32'h4184,      0, 0);
        add("stall_h",     0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h4184,      1, 0);
        add("eret_hold",   0, 1, 0, 32'h0,         0, 1, 32'h6FFC,      32'h6FFC,      0, 0);
        add("above_im",    0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h7000,      0, 4);
        add("jump_top",    0, 0, 2, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 4);
        add("wrap",        0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 0, 4);
        add("hold_zero",   0, 1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 1, 4);
        add("rst_install", 1, 1, 2, 32'h5000,      0, 0, 32'h0,         32'h3000,      0, 0);
        add("to_vec",      0, 0, 0, 32'h0,         1, 0, 32'h0,         32'h4180,      2, 0);
        add("rst_invec",   1, 1, 1, 32'h5000,      1, 1, 32'h3100,      32'h3000,      0, 0);
        add("post_rst",    0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h3004,      0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].sel, vecs[i].tgt, vecs[i].rq,
                  vecs[i].er, vecs[i].epc);
            check({vecs[i].name, ".pc"}, F_PC, vecs[i].e_pc);
            check({vecs[i].name, ".state"}, {30'd0, F_state}, {30'd0, vecs[i].e_st});
            check({vecs[i].name, ".exc"}, {27'd0, F_ExcCode}, {27'd0, vecs[i].e_exc});
        end

`ifdef F_FETCH_CNT_EN
        // 10 cycles after reset, 3 of them stalled, then reset mid-stall.
        drive(1, 0, 0, 0, 0, 0, 0);
        check("cnt.reset", F_fetch_cnt, 32'd0);
        for (int c = 0; c < 10; c++) begin
            drive(0, (c == 2 || c == 5 || c == 8), 0, 0, 0, 0, 0);
        end
        check("cnt.ten_cycles", F_fetch_cnt, 32'd7);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("cnt.stalled", F_fetch_cnt, 32'd7);
        drive(1, 1, 0, 0, 0, 0, 0);
        check("cnt.rst_pc", F_PC, 32'h3000);
        check("cnt.rst_cnt", F_fetch_cnt, 32'd0);
`endif

        // Randomized run against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            logic        r_rst, r_st, r_rq, r_er;
            logic [1:0]  r_sel;
            logic [31:0] r_tgt, r_epc;
            r_rst = ($urandom_range(0, 49) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_rq  = ($urandom_range(0, 15) == 0);
            r_er  = ($urandom_range(0, 11) == 0);
            r_sel = 2'($urandom_range(0, 3));
            r_tgt = rand_addr();
            r_epc = rand_addr();
            drive(r_rst, r_st, r_sel, r_tgt, r_rq, r_er, r_epc);
            model_step(r_rst, r_st, r_sel, r_tgt, r_rq, r_er, r_epc);
            check("rand.pc", F_PC, m_pc);
            check("rand.state", {30'd0, F_state}, m_st);
            check("rand.exc", {27'd0, F_ExcCode}, {27'd0, exp_exc(m_pc)});
`ifdef F_FETCH_CNT_EN
            check("rand.cnt", F_fetch_cnt, m_cnt);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
